fsm_operand_feeder: RTL and testbench

//  Upstream stage of the 8-state encode/arith FSM core. Buffers a byte stream in
//  a small FIFO, pairs consecutive bytes into operands (A then B), and runs one

---
 rtl/fsm_operand_feeder.sv | 141 ++++++++++++++
 tb/tb_fsm_operand_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_operand_feeder.sv
// Byte FIFO + pairing FSM feeding the encode/arith core: start, operand A, operand B, wait for done.
// Optional transaction counter enabled by defining FEEDER_PERF_CNT_EN.
module fsm_operand_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        core_start,
  output logic [7:0]  core_data_in,
  input  logic        core_done,
  input  logic [7:0]  core_data_out,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        err_timeout,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] PAIR_CNT = (AW + 1)'(2);
  localparam logic [7:0]  WD_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_OPA, S_OPB, S_WAIT} state_t;

  state_t         state, state_nx;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           push, pop;
  logic           done_q, done_rise;
  logic           wd_clr, wd_hit, res_load;
  logic [7:0]     wd_cnt;

  // Readiness comes from the registered count only, so a pop never opens the door in the same cycle.
  assign in_ready  = (count < FULL_CNT);
  assign push      = in_valid & in_ready;
  assign done_rise = core_done & ~done_q;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    core_start   = 1'b0;
    core_data_in = 8'h00;
    pop          = 1'b0;
    wd_clr       = 1'b0;
    wd_hit       = 1'b0;
    res_load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (count >= PAIR_CNT) state_nx = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_nx   = S_OPA;
      end
      S_OPA: begin
        core_data_in = mem[rd_ptr];
        pop          = 1'b1;
        state_nx     = S_OPB;
      end
      S_OPB: begin
        core_data_in = mem[rd_ptr];
        pop          = 1'b1;
        wd_clr       = 1'b1;
        state_nx     = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          res_load = 1'b1;
          state_nx = S_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          wd_hit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // done_q tracks the core level in every state, so a level already high on entry to S_WAIT is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      wd_cnt      <= 8'h00;
      res_valid   <= 1'b0;
      res_data    <= 8'h00;
      err_timeout <= 1'b0;
    end else begin
      done_q    <= core_done;
      res_valid <= res_load;
      if (res_load) res_data <= core_data_out;
      if (wd_hit)   err_timeout <= 1'b1;
      if (wd_clr)                  wd_cnt <= 8'h00;
      else if (state == S_WAIT)    wd_cnt <= wd_cnt + 8'd1;
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [15:0] txn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        txn_q <= 16'h0000;
    else if (res_load) txn_q <= txn_q + 16'd1;
  end

  assign txn_count = txn_q;
`else
  assign txn_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fsm_operand_feeder.sv
// Directed self-checking bench for fsm_operand_feeder with a behavioural core (done 8 cycles after start).
// Expected txn_count follows FEEDER_PERF_CNT_EN.
module tb_fsm_operand_feeder;

  localparam int TIMEOUT = 31;
`ifdef FEEDER_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        core_start;
  logic [7:0]  core_data_in;
  logic        core_done;
  logic [7:0]  core_data_out;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        err_timeout;
  logic        busy;
  logic [15:0] txn_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int start_cnt = 0;
  logic [7:0] res_q[$];

  bit stall = 1'b0;
  int dly;
  logic [7:0] opa, opb;

  fsm_operand_feeder #(.DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_data_in(core_data_in),
    .core_done(core_done), .core_data_out(core_data_out),
    .res_valid(res_valid), .res_data(res_data),
    .err_timeout(err_timeout), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: latches A and B on the two cycles after start, raises done 8 cycles after start with A+B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= 0; core_done <= 1'b0; core_data_out <= 8'h00; opa <= 8'h00; opb <= 8'h00;
    end else if (core_start) begin
      dly <= 1; core_done <= 1'b0;
    end else if (dly != 0) begin
      if (dly == 1) opa <= core_data_in;
      if (dly == 2) opb <= core_data_in;
      if (dly == 7 && !stall) begin
        core_done <= 1'b1; core_data_out <= opa + opb;
      end
      if (dly == 10) begin
        core_done <= 1'b0; dly <= 0;
      end else dly <= dly + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && core_start) start_cnt <= start_cnt + 1;
    if (rst_n && res_valid)  res_q.push_back(res_data);
  end

  function automatic logic [31:0] expTxn(input int n);
    return PERF ? n : 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitStart(output int sc);
    int n = 0;
    @(negedge clk);
    while (!core_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!core_start) checkOutput("start_timeout", 32'd0, 32'd1);
    sc = cyc;
  endtask

  task automatic waitRes(input int target);
    int n = 0;
    while (res_q.size() < target && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (res_q.size() < target) checkOutput("res_timeout", res_q.size(), target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int s, n, sc_before;
    logic [7:0] exp_b [5];
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_start", core_start, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_err", err_timeout, 1'b0);
    checkOutput("rst_data_in", core_data_in, 8'h00);
    checkOutput("rst_txn", txn_count, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", in_ready, 1'b1);

    // Single transaction: operand sequencing and start->result latency.
    applyStimulus(8'h05);
    applyStimulus(8'h03);
    waitStart(s);
    @(negedge clk);
    checkOutput("t1_start_one_cycle", core_start, 1'b0);
    checkOutput("t1_opa", core_data_in, 8'h05);
    @(negedge clk);
    checkOutput("t1_opb", core_data_in, 8'h03);
    @(negedge clk);
    checkOutput("t1_wait_bus_zero", core_data_in, 8'h00);
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t1_latency", cyc - s, 9);
    checkOutput("t1_res_data", res_data, 8'h08);
    @(negedge clk);
    checkOutput("t1_res_pulse", res_valid, 1'b0);
    checkOutput("t1_txn", txn_count, expTxn(1));

    // Lone byte must wait for its partner.
    sc_before = start_cnt;
    applyStimulus(8'h11);
    repeat (20) @(negedge clk);
    checkOutput("t6_no_start", start_cnt, sc_before);
    checkOutput("t6_idle", busy, 1'b0);
    applyStimulus(8'h22);
    waitRes(2);
    checkOutput("t6_res", res_q[1], 8'h33);

    // Back-to-back pairs.
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h30);
    applyStimulus(8'h40); applyStimulus(8'h50); applyStimulus(8'h60);
    waitRes(5);
    checkOutput("t2_res0", res_q[2], 8'h30);
    checkOutput("t2_res1", res_q[3], 8'h70);
    checkOutput("t2_res2", res_q[4], 8'hB0);
    repeat (2) @(negedge clk);
    checkOutput("t2_txn", txn_count, expTxn(5));

    // Stalled core: fill the FIFO, reject overflow, then hit the watchdog.
    stall = 1'b1;
    applyStimulus(8'hA0);
    applyStimulus(8'hA1);
    waitStart(s);
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    @(negedge clk);
    checkOutput("t3_full_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_full_hold", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    while (cyc < s + TIMEOUT) @(negedge clk);
    checkOutput("t4_err_not_yet", err_timeout, 1'b0);
    checkOutput("t4_busy_wait", busy, 1'b1);
    n = 0;
    while (!err_timeout && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_err_set", err_timeout, 1'b1);
    checkOutput("t4_back_idle", busy, 1'b0);
    checkOutput("t4_no_result", res_q.size(), 5);
    stall = 1'b0;

    // Push in S_OPB coincides with the pop, so count stays at 7 and one more push refills to 8.
    waitStart(s);
    in_valid = 1'b1; in_data = 8'hC0;
    checkOutput("t3_ready_start", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("t3_ready_opa", in_ready, 1'b0);
    @(negedge clk);
    checkOutput("t3_ready_opb", in_ready, 1'b1);
    @(negedge clk);
    checkOutput("t3_pushpop_keep", in_ready, 1'b1);
    in_data = 8'h02;
    @(negedge clk);
    checkOutput("t3_refill_full", in_ready, 1'b0);
    in_valid = 1'b0;
    waitRes(10);
    exp_b[0] = 8'h03; exp_b[1] = 8'h07; exp_b[2] = 8'h0B; exp_b[3] = 8'h0F; exp_b[4] = 8'hC2;
    for (int i = 0; i < 5; i++) checkOutput($sformatf("t3_res%0d", i), res_q[5 + i], exp_b[i]);
    checkOutput("t4_err_sticky", err_timeout, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t3_txn", txn_count, expTxn(10));

    // Reset in S_OPB drops everything, including the unissued B.
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    waitStart(s);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_opb_bus", core_data_in, 8'h88);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_data_in", core_data_in, 8'h00);
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_rst_err", err_timeout, 1'b0);
    checkOutput("t5_rst_txn", txn_count, 16'h0000);
    checkOutput("t5_rst_start", core_start, 1'b0);
    checkOutput("t5_rst_res_valid", res_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sc_before = start_cnt;
    repeat (20) @(negedge clk);
    checkOutput("t5_no_leftover", start_cnt, sc_before);
    checkOutput("t5_idle", busy, 1'b0);
    n = res_q.size();
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    waitRes(n + 1);
    checkOutput("t5_res", res_q[n], 8'h46);
    repeat (2) @(negedge clk);
    checkOutput("t5_txn", txn_count, expTxn(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
